// File: rtl/segment_pattern_reader.sv
// Segment-bus receiver: synchronizes and debounces a..g, decodes the displayed BCD digit
// and presents each new stable pattern as one word on a valid/ready handshake.
module segment_pattern_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic ready,
    output logic valid,
    output logic b3,
    output logic b2,
    output logic b1,
    output logic b0,
    output logic err,
    output logic blank,
    output logic overrun
);

    // state | meaning
    // IDLE  | no word pending, valid=0
    // PEND  | word held on outputs, valid=1 until accepted
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [6:0]       seg_raw;
    logic [6:0]       sync1;
    logic [6:0]       sync_pat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             changed;
    logic             report;
    logic [6:0]       last_pat;
    logic             last_v;
    logic             rep_q;
    logic [6:0]       rep_pat;
    logic [5:0]       word;
    state_t           state;

    assign seg_raw = {a, b, c, d, e, f, g};

    // Returns {err, blank, bcd[3:0]}
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'b1111110: r = 6'b00_0000;
            7'b0110000: r = 6'b00_0001;
            7'b1101101: r = 6'b00_0010;
            7'b1111001: r = 6'b00_0011;
            7'b0110011: r = 6'b00_0100;
            7'b1011011: r = 6'b00_0101;
            7'b1011111: r = 6'b00_0110;
            7'b1110000: r = 6'b00_0111;
            7'b1111111: r = 6'b00_1000;
            7'b1111011: r = 6'b00_1001;
            7'b0000000: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    // sync1 is what sync_pat becomes on this edge, so compare against it
    always_comb begin
        changed  = (sync1 != sync_pat);
        cnt_next = cnt;
        if (changed)
            cnt_next = ONE;
        else if (cnt != STABLE)
            cnt_next = cnt + ONE;
        report = (cnt_next == STABLE) && (changed || (cnt != STABLE))
                 && (!last_v || (sync1 != last_pat));
    end

    assign word = decode(rep_pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync_pat <= '0;
            cnt      <= '0;
            last_pat <= '0;
            last_v   <= 1'b0;
            rep_q    <= 1'b0;
            rep_pat  <= '0;
        end else begin
            sync1    <= seg_raw;
            sync_pat <= sync1;
            cnt      <= cnt_next;
            rep_q    <= report;
            if (report) begin
                rep_pat  <= sync1;
                last_pat <= sync1;
                last_v   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid   <= 1'b0;
            err     <= 1'b0;
            blank   <= 1'b0;
            overrun <= 1'b0;
            {b3, b2, b1, b0} <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (rep_q) begin
                        state <= PEND;
                        valid <= 1'b1;
                        {err, blank, b3, b2, b1, b0} <= word;
                    end
                end
                PEND: begin
                    if (rep_q) begin
                        {err, blank, b3, b2, b1, b0} <= word;
                        overrun <= !ready;
                    end else if (ready) begin
                        state   <= IDLE;
                        valid   <= 1'b0;
                        overrun <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_pattern_reader.sv
// Directed bench for segment_pattern_reader with hand-computed expectations.
module tb_segment_pattern_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c, d, e, f, g;
    logic ready;
    logic valid, b3, b2, b1, b0, err, blank, overrun;

    int checks = 0;
    int errors = 0;

    int         nw;
    logic [3:0] wb[16];
    logic       werr[16];
    logic       wblank[16];

    segment_pattern_reader dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .ready(ready), .valid(valid),
        .b3(b3), .b2(b2), .b1(b1), .b0(b0),
        .err(err), .blank(blank), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pat(input logic [6:0] p);
        {a, b, c, d, e, f, g} = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each cycle sampled with valid&&ready is one word accepted at the next edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid && ready && nw < 16) begin
                wb[nw]     = {b3, b2, b1, b0};
                werr[nw]   = err;
                wblank[nw] = blank;
                nw++;
            end
        end
    endtask

    function automatic logic [6:0] digit_pat(input int dgt);
        case (dgt)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    initial begin
        // 1: reset state, latency and one-cycle handshake
        rst_n = 1'b0;
        ready = 1'b1;
        set_pat(7'b1111001);
        tick();
        tick();
        check("rst_valid",   {7'b0, valid}, 8'h00);
        check("rst_word",    {2'b0, err, blank, b3, b2, b1, b0}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check("t1_valid_e5", {7'b0, valid}, 8'h00);
        tick();
        check("t1_valid_e6", {7'b0, valid}, 8'h01);
        check("t1_word",     {2'b0, err, blank, b3, b2, b1, b0}, 8'h03);
        tick();
        check("t1_valid_e7", {7'b0, valid}, 8'h00);

        // 2: short glitch back to last reported pattern
        nw = 0;
        set_pat(7'b0110000);
        run(10);
        check("t2_nw1", 8'(nw), 8'd1);
        check("t2_b1",  {4'b0, wb[0]}, 8'h01);
        nw = 0;
        set_pat(7'b1111111);
        run(2);
        set_pat(7'b0110000);
        run(10);
        check("t2_noreport", 8'(nw), 8'd0);

        // 3: illegal pattern, then blank
        nw = 0;
        set_pat(7'b1000001);
        run(10);
        check("t3_nw_illegal", 8'(nw), 8'd1);
        check("t3_illegal", {2'b0, werr[0], wblank[0], wb[0]}, 8'h20);
        nw = 0;
        set_pat(7'b0000000);
        run(10);
        check("t3_nw_blank", 8'(nw), 8'd1);
        check("t3_blank", {2'b0, werr[0], wblank[0], wb[0]}, 8'h10);

        // 4: overwrite while stalled
        ready = 1'b0;
        set_pat(7'b1101101);
        run(10);
        check("t4_hold2", {3'b0, valid, b3, b2, b1, b0}, 8'h12);
        check("t4_ovr0",  {7'b0, overrun}, 8'h00);
        set_pat(7'b1011011);
        run(10);
        check("t4_hold5", {3'b0, valid, b3, b2, b1, b0}, 8'h15);
        check("t4_ovr1",  {7'b0, overrun}, 8'h01);
        ready = 1'b1;
        tick();
        check("t4_drain_valid", {7'b0, valid}, 8'h00);
        check("t4_drain_ovr",   {7'b0, overrun}, 8'h00);

        // 5: canonical sweep
        nw = 0;
        for (int dg = 0; dg < 10; dg++) begin
            set_pat(digit_pat(dg));
            run(10);
        end
        check("t5_nw", 8'(nw), 8'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t5_word%0d", k), {2'b0, werr[k], wblank[k], wb[k]}, 8'(k));
        end

        // 6: reset during stabilization
        set_pat(7'b1111111);
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", {valid, err, blank, overrun, b3, b2, b1, b0}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        nw = 0;
        run(12);
        check("t6_nw", 8'(nw), 8'd1);
        check("t6_word", {2'b0, werr[0], wblank[0], wb[0]}, 8'h08);

        // 7: reset while a word is pending clears it without a clock edge
        ready = 1'b0;
        set_pat(7'b1110000);
        run(8);
        check("t7_pend", {3'b0, valid, b3, b2, b1, b0}, 8'h17);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_out", {valid, err, blank, overrun, b3, b2, b1, b0}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
